row_slider: RTL and testbench

- Consumer side of the level controller's speed/num_blocks interface, and the producer of its next_signal.
- Slides a row of lit columns back and forth across the playfield at a rate set by speed.
- On a player stop press, judges the row against the stack beneath it.
- Success: pulses next_signal and narrows the stack base to the overlap. Total miss: pulses game_over.

---
 rtl/row_slider.sv | 187 ++++++++++++++++++
 tb/tb_row_slider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/row_slider.sv
// row_slider: slides a row of lit columns back and forth across the playfield
// and, on a stop press, judges it against the stack top. A hit narrows the
// stack base to the overlap and pulses next_signal; a total miss pulses
// game_over and restores a full-width base.
//
// Pulse semantics: start and stop_btn are single-cycle strobes sampled on the
// rising clk edge; start is honoured only in IDLE and stop_btn only in MOVE.
// next_signal and game_over are registered, one cycle wide, and only ever
// appear in the cycle after JUDGE.
module row_slider #(
    parameter int COLS        = 8,
    parameter int PERIOD_UNIT = 250000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            stop_btn,
    input  logic [3:0]      speed,
    input  logic [3:0]      num_blocks,
    output logic [COLS-1:0] row_mask,
    output logic [COLS-1:0] base_mask,
    output logic            moving,
    output logic            next_signal,
    output logic            game_over,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MOVE  = 2'd2,
        S_JUDGE = 2'd3
    } state_t;

    localparam logic [4:0] COLS5 = 5'(COLS);

    state_t      state, state_nxt;
    logic [3:0]  spd_q;
    logic [4:0]  w_q;
    logic [4:0]  pos_q;
    logic        dir_q;      // 0 = moving right (toward higher bits), 1 = left
    logic [31:0] tick_q;

    logic [4:0]  pop_cnt;
    logic [4:0]  nb_clamp;
    logic [4:0]  w_load;
    logic [3:0]  spd_load;
    logic [31:0] period;
    logic        tick_last;
    logic [4:0]  max_pos;
    logic [4:0]  step_pos;
    logic        step_dir;
    logic [COLS-1:0] ov;

    // Mask with the low n bits set; n may equal COLS.
    function automatic logic [COLS-1:0] ones_mask(input logic [4:0] n);
        logic [COLS-1:0] m;
        for (int i = 0; i < COLS; i++) begin
            m[i] = (5'(i) < n);
        end
        return m;
    endfunction

    // Count surviving stack columns; the new row can never be wider than that.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < COLS; i++) begin
            pop_cnt = pop_cnt + {4'd0, base_mask[i]};
        end
    end

    // Row width and speed that LOAD will latch, with 0 and overflow clamped.
    always_comb begin
        if (num_blocks == 4'd0)
            nb_clamp = 5'd1;
        else if ({1'b0, num_blocks} > COLS5)
            nb_clamp = COLS5;
        else
            nb_clamp = {1'b0, num_blocks};
        w_load   = (nb_clamp < pop_cnt) ? nb_clamp : pop_cnt;
        spd_load = (speed == 4'd0) ? 4'd1 : speed;
    end

    assign period    = 32'(PERIOD_UNIT) * (32'd16 - 32'(spd_q));
    assign tick_last = (tick_q == period - 32'd1);
    assign max_pos   = COLS5 - w_q;
    assign ov        = row_mask & base_mask;
    assign moving    = (state == S_MOVE);
    assign state_dbg = state;

    // Bounce rule: reverse at either end, a full-width row stays put.
    always_comb begin
        step_pos = pos_q;
        step_dir = dir_q;
        if (max_pos == 5'd0) begin
            step_pos = 5'd0;
        end else if (!dir_q) begin
            if (pos_q == max_pos) begin
                step_dir = 1'b1;
                step_pos = pos_q - 5'd1;
            end else begin
                step_pos = pos_q + 5'd1;
            end
        end else begin
            if (pos_q == 5'd0) begin
                step_dir = 1'b0;
                step_pos = 5'd1;
            end else begin
                step_pos = pos_q - 5'd1;
            end
        end
    end

    // State register; reset wins in every state.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_MOVE;
            S_MOVE:  if (stop_btn) state_nxt = S_JUDGE;
            S_JUDGE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Row position, tick counter, masks and result pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_mask    <= '0;
            base_mask   <= '1;
            next_signal <= 1'b0;
            game_over   <= 1'b0;
            spd_q       <= 4'd1;
            w_q         <= 5'd1;
            pos_q       <= 5'd0;
            dir_q       <= 1'b0;
            tick_q      <= '0;
        end else begin
            next_signal <= 1'b0;
            game_over   <= 1'b0;
            case (state)
                S_LOAD: begin
                    spd_q    <= spd_load;
                    w_q      <= w_load;
                    pos_q    <= 5'd0;
                    dir_q    <= 1'b0;
                    tick_q   <= '0;
                    row_mask <= ones_mask(w_load);
                end
                S_MOVE: begin
                    // A stop press freezes the row so the visible mask is judged.
                    if (!stop_btn) begin
                        if (tick_last) begin
                            tick_q   <= '0;
                            pos_q    <= step_pos;
                            dir_q    <= step_dir;
                            row_mask <= ones_mask(w_q) << step_pos;
                        end else begin
                            tick_q <= tick_q + 32'd1;
                        end
                    end
                end
                S_JUDGE: begin
                    if (ov != '0) begin
                        next_signal <= 1'b1;
                        base_mask   <= ov;
                        row_mask    <= ov;
                    end else begin
                        game_over <= 1'b1;
                        base_mask <= '1;
                        row_mask  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_row_slider.sv
// Directed bench for row_slider with COLS=8, PERIOD_UNIT=1.
module tb_row_slider;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       stop_btn;
    logic [3:0] speed;
    logic [3:0] num_blocks;
    logic [7:0] row_mask;
    logic [7:0] base_mask;
    logic       moving;
    logic       next_signal;
    logic       game_over;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    row_slider #(.COLS(8), .PERIOD_UNIT(1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop_btn   (stop_btn),
        .speed      (speed),
        .num_blocks (num_blocks),
        .row_mask   (row_mask),
        .base_mask  (base_mask),
        .moving     (moving),
        .next_signal(next_signal),
        .game_over  (game_over),
        .state_dbg  (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   32'(row_mask),    32'h00);
        check({tag, "_base"},  32'(base_mask),   32'hFF);
        check({tag, "_mov"},   32'(moving),      32'd0);
        check({tag, "_ns"},    32'(next_signal), 32'd0);
        check({tag, "_go"},    32'(game_over),   32'd0);
        check({tag, "_state"}, 32'(state_dbg),   32'd0);
    endtask

    // Pulse start for one cycle (the LOAD cycle), then enter MOVE.
    task automatic launch(input logic [3:0] spd, input logic [3:0] nb);
        speed      = spd;
        num_blocks = nb;
        start      = 1'b1;
        step();
        check("load_state", 32'(state_dbg), 32'd1);
        start = 1'b0;
        step();
        check("move_state", 32'(state_dbg), 32'd2);
        check("move_flag",  32'(moving),    32'd1);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        stop_btn   = 1'b0;
        speed      = 4'd15;
        num_blocks = 4'd3;
        step();
        step();
        check_reset_outputs("reset");
        resetn = 1'b1;
        step();

        // Row 1: full bounce sequence over an untouched base, stop at 0x1C.
        exp_q = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38, 8'h1C};
        launch(4'd15, 4'd3);
        check("r1_first", 32'(row_mask), 32'h07);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            step();
            check("r1_slide", 32'(row_mask), 32'(e));
        end
        // Stop coincides with a step: the pre-step 0x1C must be judged.
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
        check("r1_judge_state", 32'(state_dbg), 32'd3);
        check("r1_judge_row",   32'(row_mask),  32'h1C);
        check("r1_ns_early",    32'(next_signal), 32'd0);
        step();
        check("r1_ns",    32'(next_signal), 32'd1);
        check("r1_go",    32'(game_over),   32'd0);
        check("r1_base",  32'(base_mask),   32'h1C);
        check("r1_row",   32'(row_mask),    32'h1C);
        check("r1_idle",  32'(state_dbg),   32'd0);
        step();
        check("r1_ns_off", 32'(next_signal), 32'd0);
        check("r1_hold",   32'(row_mask),    32'h1C);

        // Row 2: w=3 over base 0x1C, start pulse during MOVE is ignored.
        launch(4'd15, 4'd3);
        check("r2_first", 32'(row_mask), 32'h07);
        step();
        check("r2_s1", 32'(row_mask), 32'h0E);
        start = 1'b1;
        step();
        start = 1'b0;
        check("r2_start_ign_state", 32'(state_dbg), 32'd2);
        check("r2_start_ign_row",   32'(row_mask),  32'h1C);
        step();
        check("r2_s3", 32'(row_mask), 32'h38);
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
        check("r2_judge_row", 32'(row_mask), 32'h38);
        step();
        check("r2_ns",   32'(next_signal), 32'd1);
        check("r2_base", 32'(base_mask),   32'h18);
        check("r2_row",  32'(row_mask),    32'h18);

        // Row 3: popcount limits width to 2; stopping at 0x03 misses 0x18.
        launch(4'd15, 4'd3);
        check("r3_first", 32'(row_mask), 32'h03);
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
        check("r3_judge_row", 32'(row_mask), 32'h03);
        step();
        check("r3_go",   32'(game_over),   32'd1);
        check("r3_ns",   32'(next_signal), 32'd0);
        check("r3_base", 32'(base_mask),   32'hFF);
        check("r3_row",  32'(row_mask),    32'h00);
        step();
        check("r3_go_off", 32'(game_over), 32'd0);

        // speed=14: one step every 2 cycles.
        launch(4'd14, 4'd3);
        check("s14_c0", 32'(row_mask), 32'h07);
        step();
        check("s14_c1", 32'(row_mask), 32'h07);
        step();
        check("s14_c2", 32'(row_mask), 32'h0E);
        step();
        check("s14_c3", 32'(row_mask), 32'h0E);
        step();
        check("s14_c4", 32'(row_mask), 32'h1C);

        // Reset mid-MOVE returns every output to its reset value.
        resetn = 1'b0;
        step();
        check_reset_outputs("mid_reset");
        resetn = 1'b1;
        step();

        // speed=0 behaves as 1: one step every 15 cycles.
        launch(4'd0, 4'd3);
        for (int i = 0; i < 14; i++) begin
            step();
        end
        check("s0_c14", 32'(row_mask), 32'h07);
        step();
        check("s0_c15", 32'(row_mask), 32'h0E);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // num_blocks=8: full width, never moves.
        launch(4'd15, 4'd8);
        check("nb8_first", 32'(row_mask), 32'hFF);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("nb8_still", 32'(row_mask), 32'hFF);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // num_blocks=0 behaves as 1; 12 clamps to COLS.
        launch(4'd15, 4'd0);
        check("nb0_first", 32'(row_mask), 32'h01);
        step();
        check("nb0_s1", 32'(row_mask), 32'h02);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        launch(4'd15, 4'd12);
        check("nb12_clamp", 32'(row_mask), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
